// File: rtl/btn_conditioner_pkg.sv
// Shared types and helpers for the push-button conditioner.
package btn_pkg;

    // Per-channel debounce state.
    //   ZERO    | accepted low, watching for a rising level
    //   WAIT_HI | rising level seen, counting sample ticks before accepting high
    //   ONE     | accepted high, long-press counter running
    //   WAIT_LO | falling level seen, counting sample ticks before accepting low
    typedef enum logic [1:0] {
        ZERO    = 2'd0,
        WAIT_HI = 2'd1,
        ONE     = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

    // Debounced level for a given state.
    // Early mode reports the new level as soon as the first edge is seen and
    // then locks out. Delayed mode reports it only once the level is accepted.
    function automatic logic db_level(input db_state_t st, input bit early);
        if (early) begin
            return (st == WAIT_HI) || (st == ONE);
        end
        return (st == ONE) || (st == WAIT_LO);
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button-side bundle: raw levels in, conditioned level and event ticks out.
// rel is the release tick; the plain word is a reserved keyword.
interface btn_conditioner_if #(
    parameter int N = 4
);
    logic [N-1:0] btn;
    logic [N-1:0] db;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] long_tick;

    modport master (
        output btn,
        input  db,
        input  press,
        input  rel,
        input  long_tick
    );

    modport slave (
        input  btn,
        output db,
        output press,
        output rel,
        output long_tick
    );
endinterface

// File: rtl/btn_conditioner_db_channel.sv
// One debounce channel: state machine, tick counters and registered outputs.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ZERO    | accepted low; a high sample starts WAIT_HI
//   WAIT_HI | counting DB_TICKS sample ticks toward accepting high
//   ONE     | accepted high; lcnt counts ticks toward the long press
//   WAIT_LO | counting DB_TICKS sample ticks toward accepting low
module db_channel
    import btn_pkg::*;
#(
    parameter int DB_TICKS   = 3,
    parameter int LONG_TICKS = 100,
    parameter bit EARLY      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic s,
    input  logic stick,
    output logic db,
    output logic press,
    output logic rel,
    output logic long_tick
);

    localparam int CW = $clog2(DB_TICKS + 1);
    localparam int LW = $clog2(LONG_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);
    localparam logic [LW-1:0] LCNT_MAX = LW'(LONG_TICKS);

    db_state_t     state;
    db_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [LW-1:0] lcnt;
    logic [LW-1:0] lcnt_nxt;
    logic          cnt_done;
    logic          db_nxt;

    // The tick on which cnt reaches DB_TICKS closes the debounce window.
    assign cnt_done = stick && (cnt == CNT_LAST);
    assign db_nxt   = db_level(state, EARLY);

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ZERO;
            cnt   <= '0;
            lcnt  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lcnt  <= lcnt_nxt;
        end
    end

    // Next-state and counter update. A level reversal during a debounce
    // window aborts it in delayed mode; early mode rides out the whole
    // window and decides on the level present when it closes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lcnt_nxt  = lcnt;
        unique case (state)
            ZERO: begin
                if (s) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!EARLY && !s) begin
                    state_nxt = ZERO;
                end else if (stick) begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt_done) begin
                        if (s) begin
                            state_nxt = ONE;
                            lcnt_nxt  = '0;
                        end else begin
                            state_nxt = ZERO;
                        end
                    end
                end
            end
            ONE: begin
                if (!s) begin
                    // lcnt is kept so a bounce that returns to ONE resumes the hold.
                    state_nxt = WAIT_LO;
                    cnt_nxt   = '0;
                end else if (stick && (lcnt != LCNT_MAX)) begin
                    lcnt_nxt = lcnt + LW'(1);
                end
            end
            WAIT_LO: begin
                if (!EARLY && s) begin
                    state_nxt = ONE;
                end else if (stick) begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt_done) begin
                        state_nxt = s ? ONE : ZERO;
                    end
                end
            end
            default: begin
                state_nxt = ZERO;
            end
        endcase
    end

    // Output registers: events fire in the first cycle the new db level is
    // visible, and long_tick in the cycle lcnt first reaches LONG_TICKS.
    always_ff @(posedge clk) begin
        if (reset) begin
            db        <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
            long_tick <= 1'b0;
        end else begin
            db        <= db_nxt;
            press     <= db_nxt & ~db;
            rel       <= ~db_nxt & db;
            long_tick <= (lcnt_nxt == LCNT_MAX) && (lcnt != LCNT_MAX);
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// N-channel push-button front end: shared sample-tick prescaler, two-flop
// synchronisers and one debounce channel per button.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N          = 4,
    parameter int PRESCALE   = 1_000_000,
    parameter int DB_TICKS   = 3,
    parameter int LONG_TICKS = 100,
    parameter bit EARLY      = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    btn_conditioner_if.slave bus
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;
    logic          stick;
    logic [N-1:0]  sync_a;
    logic [N-1:0]  s;
    logic [N-1:0]  db_v;
    logic [N-1:0]  press_v;
    logic [N-1:0]  rel_v;
    logic [N-1:0]  long_v;

    assign stick = (pcnt == PS_LAST);

    // Free-running sample-tick prescaler shared by every channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (stick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= '0;
            s      <= '0;
        end else begin
            sync_a <= bus.btn;
            s      <= sync_a;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        db_channel #(
            .DB_TICKS   (DB_TICKS),
            .LONG_TICKS (LONG_TICKS),
            .EARLY      (EARLY)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .s         (s[i]),
            .stick     (stick),
            .db        (db_v[i]),
            .press     (press_v[i]),
            .rel       (rel_v[i]),
            .long_tick (long_v[i])
        );
    end

    assign bus.db        = db_v;
    assign bus.press     = press_v;
    assign bus.rel       = rel_v;
    assign bus.long_tick = long_v;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: a delayed-mode and an early-mode
// instance (PRESCALE=4, DB_TICKS=3, LONG_TICKS=5, N=2) driven side by side.
// Event times are counted in clock edges after the reset-release edge; the
// button level driven in step k is first captured by edge k+1.
module tb_btn_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;

    btn_conditioner_if #(.N(2)) bus_d ();
    btn_conditioner_if #(.N(2)) bus_e ();

    btn_conditioner #(
        .N(2), .PRESCALE(4), .DB_TICKS(3), .LONG_TICKS(5), .EARLY(1'b0)
    ) u_dut_d (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_d)
    );

    btn_conditioner #(
        .N(2), .PRESCALE(4), .DB_TICKS(3), .LONG_TICKS(5), .EARLY(1'b1)
    ) u_dut_e (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_e)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_align = 0;

    // [dut][channel], dut 0 = delayed, 1 = early; -1 means never seen
    int t_rise [2][2];
    int t_fall [2][2];
    int t_press[2][2];
    int t_rel  [2][2];
    int t_long [2][2];
    int n_press[2][2];
    int n_rel  [2][2];
    int n_long [2][2];
    logic [1:0] dbp [2];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                t_rise[d][c]  = -1;
                t_fall[d][c]  = -1;
                t_press[d][c] = -1;
                t_rel[d][c]   = -1;
                t_long[d][c]  = -1;
                n_press[d][c] = 0;
                n_rel[d][c]   = 0;
                n_long[d][c]  = 0;
            end
            dbp[d] = 2'b00;
        end
    endtask

    task automatic sample();
        logic [1:0] dbv[2];
        logic [1:0] prv[2];
        logic [1:0] rlv[2];
        logic [1:0] lgv[2];
        dbv[0] = bus_d.db;    dbv[1] = bus_e.db;
        prv[0] = bus_d.press; prv[1] = bus_e.press;
        rlv[0] = bus_d.rel;   rlv[1] = bus_e.rel;
        lgv[0] = bus_d.long_tick; lgv[1] = bus_e.long_tick;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                if (dbv[d][c] && !dbp[d][c] && t_rise[d][c] < 0) t_rise[d][c] = cyc;
                if (!dbv[d][c] && dbp[d][c] && t_fall[d][c] < 0) t_fall[d][c] = cyc;
                if (prv[d][c]) begin
                    n_press[d][c]++;
                    if (t_press[d][c] < 0) t_press[d][c] = cyc;
                end
                if (rlv[d][c]) begin
                    n_rel[d][c]++;
                    if (t_rel[d][c] < 0) t_rel[d][c] = cyc;
                end
                if (lgv[d][c]) begin
                    n_long[d][c]++;
                    if (t_long[d][c] < 0) t_long[d][c] = cyc;
                end
                if (prv[d][c] != (dbv[d][c] && !dbp[d][c])) n_align++;
                if (rlv[d][c] != (!dbv[d][c] && dbp[d][c])) n_align++;
            end
            dbp[d] = dbv[d];
        end
    endtask

    task automatic step(input logic [1:0] bd, input logic [1:0] be);
        bus_d.btn = bd;
        bus_e.btn = be;
        @(posedge clk);
        #1;
        cyc++;
        sample();
    endtask

    task automatic do_reset(input int ncyc, input string tag);
        reset = 1'b1;
        repeat (ncyc) @(posedge clk);
        #1;
        check({tag, "_out_d"}, int'({bus_d.db, bus_d.press, bus_d.rel, bus_d.long_tick}), 0);
        check({tag, "_out_e"}, int'({bus_e.db, bus_e.press, bus_e.rel, bus_e.long_tick}), 0);
        reset = 1'b0;
        cyc = 0;
        clear_stats();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_d.btn = 2'b00;
        bus_e.btn = 2'b00;
        clear_stats();
        do_reset(2, "rst0");

        // Clean press held 40 cycles, then clean release (delayed).
        for (int k = 0; k < 70; k++) step((k < 40) ? 2'b01 : 2'b00, 2'b00);
        check("s1_db_rise", t_rise[0][0], 13);
        check("s1_press_t", t_press[0][0], 13);
        check("s1_press_n", n_press[0][0], 1);
        check("s1_long_t", t_long[0][0], 32);
        check("s1_long_n", n_long[0][0], 1);
        check("s1_rel_t", t_rel[0][0], 53);
        check("s1_rel_n", n_rel[0][0], 1);
        check("s1_ch1_db", t_rise[0][1], -1);
        check("s1_ch1_press", n_press[0][1], 0);
        check("s1_ch1_long", n_long[0][1], 0);

        // Bounce: delayed never accepts; early takes the first edge and
        // rides out the lockout, then a clean release at step 40.
        do_reset(2, "rst1");
        for (int k = 0; k < 60; k++) begin
            step((k < 30 && (k % 3) == 0) ? 2'b01 : 2'b00,
                 (k == 0 || k == 3 || (k >= 6 && k < 40)) ? 2'b01 : 2'b00);
        end
        check("s2_d_db_rise", t_rise[0][0], -1);
        check("s2_d_press_n", n_press[0][0], 0);
        check("s2_d_rel_n", n_rel[0][0], 0);
        check("s2_e_db_rise", t_rise[1][0], 4);
        check("s2_e_press_n", n_press[1][0], 1);
        check("s2_e_press_t", t_press[1][0], 4);
        check("s2_e_long_t", t_long[1][0], 32);
        check("s2_e_rel_t", t_rel[1][0], 44);
        check("s2_e_rel_n", n_rel[1][0], 1);

        // WAIT_LO excursions in delayed mode: a 2-cycle low dip while the
        // hold is counting (lcnt must survive), then a release with one
        // high cycle inside WAIT_LO.
        do_reset(2, "rst2");
        for (int k = 0; k < 75; k++) begin
            logic b;
            b = (k < 22) || (k >= 24 && k < 44) || (k == 47);
            step({1'b0, b}, 2'b00);
        end
        check("s3_press_n", n_press[0][0], 1);
        check("s3_long_t", t_long[0][0], 32);
        check("s3_long_n", n_long[0][0], 1);
        check("s3_db_fall", t_fall[0][0], 61);
        check("s3_rel_t", t_rel[0][0], 61);
        check("s3_rel_n", n_rel[0][0], 1);

        // Simultaneous presses on both channels.
        do_reset(2, "rst3");
        for (int k = 0; k < 20; k++) step(2'b11, 2'b00);
        check("s4_press0_t", t_press[0][0], 13);
        check("s4_press1_t", t_press[0][1], 13);
        check("s4_db_pre", int'(bus_d.db), 3);

        // One-cycle reset while both channels are high, buttons still held.
        do_reset(1, "rst4");
        for (int k = 0; k < 20; k++) step(2'b11, 2'b00);
        check("s5_db_rise", t_rise[0][0], 13);
        check("s5_rel0_n", n_rel[0][0], 0);
        check("s5_rel1_n", n_rel[0][1], 0);

        check("press_rel_align", n_align, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
